// File: rtl/irq_pkg.sv
// Shared types, limits and the handler-vector helper for the interrupt controller.
package irq_pkg;

    localparam int NCH_MAX  = 16;
    localparam int ID_MAX_W = 4;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_1000;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0100;

    // Result of a highest-set-bit search; valid=0 means "no bit set" (priority -1).
    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] idx;
    } top_t;

    localparam top_t TOP_NONE = '{valid: 1'b0, idx: '0};

    function automatic logic [63:0] vec_of(input logic [ID_MAX_W-1:0] id,
                                           input logic [63:0]         base,
                                           input logic [63:0]         stride);
        return base + 64'(id) * stride;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational highest-set-bit encoder; the highest index is the highest priority.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NCH  = 3,
    parameter int ID_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0]  vec,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (vec[i]) begin
                valid = 1'b1;
                idx   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Nesting interrupt controller: edge capture, masking, fixed priority and an
// in-service stack that only lets strictly higher priorities preempt.
module irq_prio_ctrl
    import irq_pkg::*;
#(
    parameter int               NCH        = 3,
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] VEC_BASE   = WIDTH'(DEF_VEC_BASE),
    parameter logic [WIDTH-1:0] VEC_STRIDE = WIDTH'(DEF_VEC_STRIDE),
    parameter int               ID_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   irq,
    input  logic [NCH-1:0]   mask,
    input  logic             int_ack,
    input  logic             int_ret,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic [WIDTH-1:0] int_vec,
    output logic [NCH-1:0]   pending,
    output logic [NCH-1:0]   in_service
);

    logic [NCH-1:0]   irq_q;
    logic [NCH-1:0]   pending_q, pending_d;
    logic [NCH-1:0]   in_service_q, in_service_d;
    logic             int_req_q, int_req_d;
    logic [ID_W-1:0]  int_id_q, int_id_d;
    logic [WIDTH-1:0] int_vec_q, int_vec_d;

    logic [NCH-1:0]   irq_edge;
    logic [NCH-1:0]   cand;
    logic             p_valid, s_valid;
    logic [ID_W-1:0]  p_idx, s_idx;
    top_t             p_top, s_top;
    logic             eligible;
    logic             ack_valid;
    logic [NCH-1:0]   ack_bit, ret_bit;
    logic [WIDTH-1:0] vec_next;

    assign irq_edge = irq & ~irq_q;
    assign cand     = pending_q & mask;

    irq_prio_enc #(.NCH(NCH), .ID_W(ID_W)) u_cand_enc (
        .vec   (cand),
        .valid (p_valid),
        .idx   (p_idx)
    );

    irq_prio_enc #(.NCH(NCH), .ID_W(ID_W)) u_serv_enc (
        .vec   (in_service_q),
        .valid (s_valid),
        .idx   (s_idx)
    );

    always_comb begin
        p_top = TOP_NONE;
        s_top = TOP_NONE;
        if (p_valid) begin
            p_top.valid = 1'b1;
            p_top.idx   = ID_MAX_W'(p_idx);
        end
        if (s_valid) begin
            s_top.valid = 1'b1;
            s_top.idx   = ID_MAX_W'(s_idx);
        end
        eligible = p_top.valid && (!s_top.valid || (p_top.idx > s_top.idx));
        vec_next = WIDTH'(vec_of(p_top.idx, 64'(VEC_BASE), 64'(VEC_STRIDE)));
    end

    // Ret pops the pre-cycle stack top before the ack pushes, so both can land on one edge.
    always_comb begin
        ack_valid    = int_ack && int_req_q;
        ack_bit      = ack_valid ? (NCH'(1) << int_id_q) : '0;
        ret_bit      = (int_ret && s_valid) ? (NCH'(1) << s_idx) : '0;
        pending_d    = (pending_q & ~ack_bit) | irq_edge;
        in_service_d = (in_service_q & ~ret_bit) | ack_bit;
        int_req_d    = eligible && !ack_valid;
        int_id_d     = eligible ? p_idx : int_id_q;
        int_vec_d    = eligible ? vec_next : int_vec_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q        <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            int_req_q    <= 1'b0;
            int_id_q     <= '0;
            int_vec_q    <= VEC_BASE;
        end else begin
            irq_q        <= irq;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            int_req_q    <= int_req_d;
            int_id_q     <= int_id_d;
            int_vec_q    <= int_vec_d;
        end
    end

    assign int_req    = int_req_q;
    assign int_id     = int_id_q;
    assign int_vec    = int_vec_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed-vector bench for irq_prio_ctrl with NCH=3 and default vector layout.
module tb_irq_prio_ctrl;

    logic        clk;
    logic        rst_n;
    logic [2:0]  irq;
    logic [2:0]  mask;
    logic        int_ack;
    logic        int_ret;
    logic        int_req;
    logic [1:0]  int_id;
    logic [31:0] int_vec;
    logic [2:0]  pending;
    logic [2:0]  in_service;

    int total;
    int bad;

    irq_prio_ctrl #(.NCH(3), .WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq        (irq),
        .mask       (mask),
        .int_ack    (int_ack),
        .int_ret    (int_ret),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_vec    (int_vec),
        .pending    (pending),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, step past the next rising edge, then drop ack/ret.
    task automatic applyStimulus(input logic [2:0] i_irq, input logic [2:0] i_mask,
                                 input logic i_ack, input logic i_ret);
        irq     = i_irq;
        mask    = i_mask;
        int_ack = i_ack;
        int_ret = i_ret;
        @(posedge clk);
        #1;
        int_ack = 1'b0;
        int_ret = 1'b0;
    endtask

    task automatic checkPresent(input string tag, input logic req, input logic [1:0] id,
                                input logic [31:0] vec);
        checkOutput({tag, ".req"}, 64'(int_req), 64'(req));
        checkOutput({tag, ".id"},  64'(int_id),  64'(id));
        checkOutput({tag, ".vec"}, 64'(int_vec), 64'(vec));
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        irq     = 3'b000;
        mask    = 3'b111;
        int_ack = 1'b0;
        int_ret = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkPresent("reset", 1'b0, 2'd0, 32'h1000);
        checkOutput("reset.pending", 64'(pending), 64'h0);
        checkOutput("reset.in_service", 64'(in_service), 64'h0);
        #3 rst_n = 1'b1;
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);

        // Single request on channel 1
        applyStimulus(3'b010, 3'b111, 1'b0, 1'b0);
        checkOutput("single.pending", 64'(pending), 64'b010);
        checkOutput("single.req_early", 64'(int_req), 64'h0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        checkPresent("single.present", 1'b1, 2'd1, 32'h1100);
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        checkOutput("single.ack_pending", 64'(pending), 64'b000);
        checkOutput("single.ack_inserv", 64'(in_service), 64'b010);
        checkPresent("single.ack_drop", 1'b0, 2'd1, 32'h1100);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b1);
        checkOutput("single.ret_inserv", 64'(in_service), 64'b000);

        // Priority: 0 and 2 together, 2 first, 0 waits until return
        applyStimulus(3'b101, 3'b111, 1'b0, 1'b0);
        checkOutput("prio.pending", 64'(pending), 64'b101);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        checkPresent("prio.first", 1'b1, 2'd2, 32'h1200);
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        checkOutput("prio.ack_inserv", 64'(in_service), 64'b100);
        checkOutput("prio.ack_pending", 64'(pending), 64'b001);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        checkOutput("prio.blocked_req", 64'(int_req), 64'h0);
        checkOutput("prio.blocked_pending", 64'(pending), 64'b001);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b1);
        checkOutput("prio.ret_inserv", 64'(in_service), 64'b000);
        checkOutput("prio.ret_req", 64'(int_req), 64'h0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        checkPresent("prio.second", 1'b1, 2'd0, 32'h1000);

        // Nesting: channel 0 in service, channel 2 preempts
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        checkOutput("nest.inserv0", 64'(in_service), 64'b001);
        applyStimulus(3'b100, 3'b111, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        checkPresent("nest.present", 1'b1, 2'd2, 32'h1200);
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        checkOutput("nest.inserv02", 64'(in_service), 64'b101);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b1);
        checkOutput("nest.ret1", 64'(in_service), 64'b001);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b1);
        checkOutput("nest.ret2", 64'(in_service), 64'b000);
        checkOutput("nest.idle_req", 64'(int_req), 64'h0);

        // Mask: channel 2 latched but hidden until unmasked
        applyStimulus(3'b100, 3'b011, 1'b0, 1'b0);
        checkOutput("mask.pending", 64'(pending), 64'b100);
        applyStimulus(3'b000, 3'b011, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b011, 1'b0, 1'b0);
        checkOutput("mask.req_off", 64'(int_req), 64'h0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        checkPresent("mask.unmasked", 1'b1, 2'd2, 32'h1200);
        applyStimulus(3'b000, 3'b011, 1'b0, 1'b0);
        checkOutput("mask.drop_req", 64'(int_req), 64'h0);
        checkOutput("mask.keep_pending", 64'(pending), 64'b100);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b1);
        checkOutput("mask.cleanup", 64'(in_service | pending), 64'h0);

        // Held level produces exactly one request
        applyStimulus(3'b010, 3'b111, 1'b0, 1'b0);
        applyStimulus(3'b010, 3'b111, 1'b0, 1'b0);
        checkPresent("held.present", 1'b1, 2'd1, 32'h1100);
        applyStimulus(3'b010, 3'b111, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) applyStimulus(3'b010, 3'b111, 1'b0, 1'b0);
        checkOutput("held.pending", 64'(pending), 64'b000);
        checkOutput("held.req", 64'(int_req), 64'h0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b1);
        checkOutput("held.ret", 64'(in_service), 64'b000);

        // New edge on channel 1 in the same cycle as its ack
        applyStimulus(3'b010, 3'b111, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        checkPresent("coll.present", 1'b1, 2'd1, 32'h1100);
        applyStimulus(3'b010, 3'b111, 1'b1, 1'b0);
        checkOutput("coll.pending", 64'(pending), 64'b010);
        checkOutput("coll.inserv", 64'(in_service), 64'b010);
        checkOutput("coll.req_drop", 64'(int_req), 64'h0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b1);
        checkOutput("coll.ret_req", 64'(int_req), 64'h0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        checkPresent("coll.represent", 1'b1, 2'd1, 32'h1100);
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b1);
        checkOutput("coll.cleanup", 64'(in_service | pending), 64'h0);

        // Build in_service=011, pending=100, then reset between edges
        applyStimulus(3'b001, 3'b111, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        applyStimulus(3'b010, 3'b111, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        applyStimulus(3'b100, 3'b011, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b011, 1'b0, 1'b0);
        checkOutput("rst.pre_inserv", 64'(in_service), 64'b011);
        checkOutput("rst.pre_pending", 64'(pending), 64'b100);
        checkOutput("rst.pre_vec", 64'(int_vec), 64'h1100);
        #2 rst_n = 1'b0;
        #1;
        checkPresent("rst.async", 1'b0, 2'd0, 32'h1000);
        checkOutput("rst.async_pending", 64'(pending), 64'h0);
        checkOutput("rst.async_inserv", 64'(in_service), 64'h0);
        mask = 3'b111;
        @(posedge clk);
        #1;
        checkPresent("rst.held", 1'b0, 2'd0, 32'h1000);
        #3 rst_n = 1'b1;
        #1;
        checkPresent("rst.released", 1'b0, 2'd0, 32'h1000);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        checkOutput("rst.after_edge", 64'({pending, in_service, int_req}), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_prio_ctrl.md
# irq_prio_ctrl

Parametrised, nesting-capable interrupt controller placed between external interrupt sources and the pipelined CPU's interrupt-entry logic. It generalises the fixed 3-line IRQ scheme to NCH channels, with:
- rising-edge capture into pending latches,
- per-channel masking,
- fixed priority,
- an in-service stack that permits preemption only by strictly higher priorities.

The CPU takes interrupts through an ack/return handshake and receives a precomputed handler vector.

## Interface
- NCH, 3, number of interrupt channels (1..16); channel NCH-1 is highest priority
- WIDTH, 32, vector/address width
- VEC_BASE, 32'h0000_1000, handler address of channel 0
- VEC_STRIDE, 32'h0000_0100, address step per channel
- ID_W, $clog2(NCH) (min 1), channel-id width
- clk  in  1  single system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- irq  in  NCH  raw request lines, synchronous to clk, rising edge = request
- mask  in  NCH  1 = channel enabled
- int_ack  in  1  CPU accepts the presented interrupt this cycle
- int_ret  in  1  CPU executes interrupt return this cycle
- int_req  out  NCH?1  registered request to CPU
- int_id  out  ID_W  registered id of the presented channel
- int_vec  out  WIDTH  registered VEC_BASE + int_id*VEC_STRIDE, truncated to WIDTH
- pending  out  NCH  pending latches (waiting requests)
- in_service  out  NCH  channels currently being serviced (nesting stack)

## Operation
- Edge detect:
  - irq_q holds irq from the previous cycle.
  - edge[i] = irq[i] & ~irq_q[i].
  - A level held high produces exactly one request.
- Pending:
  - pending[i] is set on edge[i], regardless of mask.
  - It is cleared when int_ack is high and int_id == i.
  - If edge[i] coincides with the clearing ack, the bit stays set; the new request wins.
- Eligibility:
  - cand = pending & mask.
  - top_p = highest set index of cand.
  - top_s = highest set index of in_service, or -1 if none.
  - Eligible iff cand != 0 and top_p > top_s.
  - Equal or lower priority waits.
- Presentation: each cycle the registers take int_req <= eligible, int_id <= top_p, and int_vec <= vector(top_p). If not eligible, int_id and int_vec hold their previous values.
- Ack:
  - Valid only while int_req = 1.
  - On a valid ack: pending[int_id] is cleared, in_service[int_id] is set, and int_req is forced to 0 on the next edge.
  - Ack while int_req = 0 is ignored.
- Return: int_ret clears the highest set bit of in_service. int_ret with in_service == 0 is ignored.
- Ack and ret in the same cycle:
  - Ret clears the top bit of the pre-cycle in_service.
  - Ack then sets its bit.
  - Both take effect at the same edge.
- Masking a channel whose request is currently presented drops int_req on the next edge; the pending bit is retained.
- Reset values: int_req 0, int_id 0, int_vec VEC_BASE, pending 0, in_service 0, irq_q 0.
- Reset mid-operation discards all pending and in-service state immediately; outputs return to reset values asynchronously.

## Timing
- irq[i] rises before edge E0 → pending[i] = 1 after E0 → int_req/int_id/int_vec valid after E1. Latency is 2 cycles.
- Ack sampled at edge Ea:
  - pending/in_service update after Ea.
  - int_req = 0 after Ea.
  - The next eligible candidate is presented after Ea+1, so there is a minimum 1 idle cycle between presentations.
- After ret at edge Er, a lower-priority waiting request appears after Er+1.
- int_vec arithmetic is done in WIDTH bits with wrap-around; there is no overflow flag.

## Structure
- Shared package irq_pkg holds:
  - NCH_MAX = 16,
  - default VEC_BASE and VEC_STRIDE,
  - function vec_of(id) returning VEC_BASE + id*VEC_STRIDE,
  - the "none" encoding for the top_s search (valid flag plus index).
- One sub-module, irq_prio_enc:
  - parametrised NCH,
  - combinational highest-set-bit encoder with outputs valid and idx[ID_W-1:0],
  - instantiated twice: once for cand, once for in_service.
- All registers live in irq_prio_ctrl.

## Test plan
- **Single request:** NCH=3, mask=3'b111, pulse irq[1] for 1 cycle.
  - int_req=1, int_id=1, int_vec=32'h1100 two cycles later.
  - After ack: pending=000, in_service=010.
  - After ret: in_service=000.
- **Priority and preemption:** irq[0] and irq[2] rise together.
  - int_id=2 is presented first; ack it.
  - irq[0] stays pending and no int_req while in_service=100.
  - After ret, int_id=0 is presented.
- **Nesting:** ack irq[0] (in_service=001), then pulse irq[2].
  - int_req=1 with int_id=2; ack gives in_service=101.
  - Ret → 001; ret → 000.
- **Mask:** mask=3'b011, pulse irq[2].
  - pending=100 and int_req stays 0.
  - Set mask=3'b111 → int_req=1, int_id=2 one cycle later.
- **Held level and ack/edge collision:**
  - irq[1] held high for 10 cycles → exactly one request.
  - A new rising edge on irq[1] in the same cycle as its ack → pending[1] remains 1 and is re-presented two cycles later.
- **Async reset mid-service:** with in_service=011 and pending=100, assert rst_n=0 between clock edges.
  - All outputs go to reset values immediately: int_vec=32'h1000, int_req=0.
  - Outputs remain there until the first edge after release.
